// File: rtl/rf_operand_fetch.sv
// rf_operand_fetch: holds one decoded instruction, gathers its source operands
// from the register file (or the writeback snoop path), invalidates the
// destination once all sources are in hand, then presents the instruction to
// execute. Retries caused by not-yet-valid registers are counted in stall_cnt.
module rf_operand_fetch #(
    parameter logic [15:0] STALL_MAX = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        dec_valid,
    output logic        dec_ready,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic [4:0]  dec_rd,
    input  logic        dec_use_rs1,
    input  logic        dec_use_rs2,
    input  logic        dec_wr_rd,
    input  logic [31:0] dec_payload,

    output logic        rf_re_p0,
    output logic [4:0]  rf_addr_p0,
    output logic        rf_re_p1,
    output logic [4:0]  rf_addr_p1,
    input  logic [31:0] rf_dout_p0,
    input  logic        rf_v_p0,
    input  logic [31:0] rf_dout_p1,
    input  logic        rf_v_p1,

    output logic        rf_we_pi,
    output logic [4:0]  rf_addr_pi,

    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,

    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [31:0] ex_op1,
    output logic [31:0] ex_op2,
    output logic [31:0] ex_payload,
    output logic [4:0]  ex_rd,
    output logic        ex_wr_rd,

    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {IDLE, READ, CHECK, ISSUE} state_t;

    state_t      state;
    state_t      state_next;

    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;
    logic [4:0]  rd_q;
    logic        use1_q;
    logic        use2_q;
    logic        wr_rd_q;
    logic [31:0] payload_q;
    logic [31:0] op1_q;
    logic [31:0] op2_q;
    logic        got1_q;
    logic        got2_q;
    logic [15:0] stall_q;

    logic [31:0] op1_n;
    logic [31:0] op2_n;
    logic        got1_n;
    logic        got2_n;
    logic        all_got;

    assign rf_addr_p0 = rs1_q;
    assign rf_addr_p1 = rs2_q;
    assign rf_addr_pi = rd_q;
    assign ex_op1     = op1_q;
    assign ex_op2     = op2_q;
    assign ex_payload = payload_q;
    assign ex_rd      = rd_q;
    assign ex_wr_rd   = wr_rd_q;
    assign stall_cnt  = stall_q;
    assign all_got    = got1_n && got2_n;

    // Operand capture: the writeback snoop wins in READ (the register file
    // would return stale data that cycle); in CHECK the read data wins, with
    // a same-cycle writeback as the fallback. x0 and unused sources are
    // already marked got at accept time, so they never reach this logic.
    always_comb begin
        op1_n  = op1_q;
        op2_n  = op2_q;
        got1_n = got1_q;
        got2_n = got2_q;
        case (state)
            READ: begin
                if (wb_we && use1_q && !got1_q && (rs1_q != 5'd0) && (wb_addr == rs1_q)) begin
                    op1_n  = wb_data;
                    got1_n = 1'b1;
                end
                if (wb_we && use2_q && !got2_q && (rs2_q != 5'd0) && (wb_addr == rs2_q)) begin
                    op2_n  = wb_data;
                    got2_n = 1'b1;
                end
            end
            CHECK: begin
                if (!got1_q) begin
                    if (rf_v_p0) begin
                        op1_n  = rf_dout_p0;
                        got1_n = 1'b1;
                    end else if (wb_we && (wb_addr == rs1_q)) begin
                        op1_n  = wb_data;
                        got1_n = 1'b1;
                    end
                end
                if (!got2_q) begin
                    if (rf_v_p1) begin
                        op2_n  = rf_dout_p1;
                        got2_n = 1'b1;
                    end else if (wb_we && (wb_addr == rs2_q)) begin
                        op2_n  = wb_data;
                        got2_n = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Next-state and handshake/port strobes; everything is forced quiet
    // while reset is high so an abandoned instruction leaves no trace.
    always_comb begin
        state_next = state;
        dec_ready  = 1'b0;
        rf_re_p0   = 1'b0;
        rf_re_p1   = 1'b0;
        rf_we_pi   = 1'b0;
        ex_valid   = 1'b0;
        case (state)
            IDLE: begin
                dec_ready = 1'b1;
                if (dec_valid) begin
                    state_next = READ;
                end
            end
            READ: begin
                rf_re_p0   = use1_q && !got1_q;
                rf_re_p1   = use2_q && !got2_q;
                state_next = CHECK;
            end
            CHECK: begin
                if (all_got) begin
                    rf_we_pi   = wr_rd_q && (rd_q != 5'd0);
                    state_next = ISSUE;
                end else begin
                    state_next = READ;
                end
            end
            ISSUE: begin
                ex_valid = 1'b1;
                if (ex_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (reset) begin
            dec_ready = 1'b0;
            rf_re_p0  = 1'b0;
            rf_re_p1  = 1'b0;
            rf_we_pi  = 1'b0;
            ex_valid  = 1'b0;
        end
    end

    // State, latched instruction fields, operands and the saturating stall
    // counter; a new instruction is only taken in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rs1_q     <= 5'd0;
            rs2_q     <= 5'd0;
            rd_q      <= 5'd0;
            use1_q    <= 1'b0;
            use2_q    <= 1'b0;
            wr_rd_q   <= 1'b0;
            payload_q <= 32'd0;
            op1_q     <= 32'd0;
            op2_q     <= 32'd0;
            got1_q    <= 1'b0;
            got2_q    <= 1'b0;
            stall_q   <= 16'd0;
        end else begin
            state <= state_next;
            if (state == IDLE) begin
                if (dec_valid) begin
                    rs1_q     <= dec_rs1;
                    rs2_q     <= dec_rs2;
                    rd_q      <= dec_rd;
                    use1_q    <= dec_use_rs1;
                    use2_q    <= dec_use_rs2;
                    wr_rd_q   <= dec_wr_rd;
                    payload_q <= dec_payload;
                    op1_q     <= 32'd0;
                    op2_q     <= 32'd0;
                    got1_q    <= !dec_use_rs1 || (dec_rs1 == 5'd0);
                    got2_q    <= !dec_use_rs2 || (dec_rs2 == 5'd0);
                end
            end else begin
                op1_q  <= op1_n;
                op2_q  <= op2_n;
                got1_q <= got1_n;
                got2_q <= got2_n;
            end
            if ((state == CHECK) && !all_got && (stall_q < STALL_MAX)) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_rf_operand_fetch.sv
// Testbench for rf_operand_fetch: a cycle-level register-file model drives the
// read ports; each instruction's expected operands, retry count, latency and
// port activity are worked out from the register contents, the number of
// invalid reads per register and the time of any writeback.
module tb_rf_operand_fetch;

    localparam logic [15:0] SAT = 16'd40;

    logic        clk = 1'b0;
    logic        reset;
    logic        dec_valid;
    logic        dec_ready;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic        dec_use_rs1;
    logic        dec_use_rs2;
    logic        dec_wr_rd;
    logic [31:0] dec_payload;
    logic        rf_re_p0;
    logic [4:0]  rf_addr_p0;
    logic        rf_re_p1;
    logic [4:0]  rf_addr_p1;
    logic [31:0] rf_dout_p0;
    logic        rf_v_p0;
    logic [31:0] rf_dout_p1;
    logic        rf_v_p1;
    logic        rf_we_pi;
    logic [4:0]  rf_addr_pi;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_op1;
    logic [31:0] ex_op2;
    logic [31:0] ex_payload;
    logic [4:0]  ex_rd;
    logic        ex_wr_rd;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    rf_operand_fetch #(.STALL_MAX(SAT)) dut (
        .clk(clk), .reset(reset),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_wr_rd(dec_wr_rd),
        .dec_payload(dec_payload),
        .rf_re_p0(rf_re_p0), .rf_addr_p0(rf_addr_p0),
        .rf_re_p1(rf_re_p1), .rf_addr_p1(rf_addr_p1),
        .rf_dout_p0(rf_dout_p0), .rf_v_p0(rf_v_p0),
        .rf_dout_p1(rf_dout_p1), .rf_v_p1(rf_v_p1),
        .rf_we_pi(rf_we_pi), .rf_addr_pi(rf_addr_pi),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_payload(ex_payload),
        .ex_rd(ex_rd), .ex_wr_rd(ex_wr_rd),
        .stall_cnt(stall_cnt)
    );

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] regs [32];
    int          pend [32];
    int          re0Cnt, re1Cnt, weCnt;
    logic [4:0]  piAddr;
    int          stallModel;

    logic        sRe0, sRe1, sWe;
    logic [4:0]  sA0, sA1, sWa;
    logic [31:0] sWd;

    // Single comparison point: counts every vector and reports miscompares.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Sample DUT outputs mid-cycle and tally read/invalidate activity.
    task automatic sampleCycle();
        @(negedge clk);
        sRe0 = rf_re_p0;
        sRe1 = rf_re_p1;
        sA0  = rf_addr_p0;
        sA1  = rf_addr_p1;
        sWe  = wb_we;
        sWa  = wb_addr;
        sWd  = wb_data;
        if (rf_re_p0 === 1'b1) re0Cnt++;
        if (rf_re_p1 === 1'b1) re1Cnt++;
        if (rf_we_pi === 1'b1) begin
            weCnt++;
            piAddr = rf_addr_pi;
        end
    endtask

    // Clock edge plus register-file model: reads return the pre-write value
    // one cycle later, pending registers read as invalid, and when a port is
    // not read its outputs carry junk.
    task automatic advance();
        @(posedge clk);
        #1;
        if (sRe0) begin
            rf_dout_p0 = regs[sA0];
            rf_v_p0    = (pend[sA0] == 0);
        end else begin
            rf_dout_p0 = $urandom;
            rf_v_p0    = 1'($urandom_range(1));
        end
        if (sRe1) begin
            rf_dout_p1 = regs[sA1];
            rf_v_p1    = (pend[sA1] == 0);
        end else begin
            rf_dout_p1 = $urandom;
            rf_v_p1    = 1'($urandom_range(1));
        end
        if (sRe0 && pend[sA0] > 0) pend[sA0] = pend[sA0] - 1;
        if (sRe1 && !(sRe0 && sA0 == sA1) && pend[sA1] > 0) pend[sA1] = pend[sA1] - 1;
        if (sWe) begin
            regs[sWa] = sWd;
            pend[sWa] = 0;
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        sampleCycle();
        advance();
        reset = 1'b0;
        stallModel = 0;
        for (int i = 0; i < 32; i++) pend[i] = 0;
    endtask

    // One instruction end to end. k1/k2 are invalid reads before a register
    // turns valid; wbAt is the cycle after accept (1 = first READ) in which a
    // writeback of wbAddr/wbData is snooped, 0 for none.
    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic u1, input logic u2, input logic wr,
                                 input logic [31:0] payload, input int k1, input int k2,
                                 input int hold, input int wbAt,
                                 input logic [4:0] wbAddr, input logic [31:0] wbData);
        logic        need1, need2, isRead, seen;
        int          k1e, k2e, r1, r2, reads1, reads2, j, retries, expLat, lat;
        logic [31:0] e1, e2;
        need1 = u1 && (rs1 != 5'd0);
        need2 = u2 && (rs2 != 5'd0);
        k1e = need1 ? k1 : 0;
        k2e = need2 ? k2 : 0;
        if (need1 && need2 && rs1 == rs2) k2e = k1e;
        pend[rs1] = 0;
        pend[rs2] = 0;
        if (need1) pend[rs1] = k1e;
        if (need2) pend[rs2] = k2e;
        e1 = need1 ? regs[rs1] : 32'd0;
        e2 = need2 ? regs[rs2] : 32'd0;
        r1 = k1e;
        r2 = k2e;
        reads1 = need1 ? k1e + 1 : 0;
        reads2 = need2 ? k2e + 1 : 0;
        j = (wbAt - 1) / 2;
        isRead = (wbAt % 2) == 1;
        if (wbAt > 0 && need1 && wbAddr == rs1 && (isRead ? (j <= k1e) : (j < k1e))) begin
            e1 = wbData; r1 = j; reads1 = j + 1;
        end
        if (wbAt > 0 && need2 && wbAddr == rs2 && (isRead ? (j <= k2e) : (j < k2e))) begin
            e2 = wbData; r2 = j; reads2 = j + 1;
        end
        retries = (r1 > r2) ? r1 : r2;
        stallModel = stallModel + retries;
        if (stallModel > int'(SAT)) stallModel = int'(SAT);
        expLat = 3 + 2 * retries;

        re0Cnt = 0; re1Cnt = 0; weCnt = 0; piAddr = 5'd0;
        dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd;
        dec_use_rs1 = u1; dec_use_rs2 = u2; dec_wr_rd = wr;
        dec_payload = payload;
        dec_valid = 1'b1;
        sampleCycle();
        checkOutput("dec_ready_idle", 32'(dec_ready), 32'd1);
        advance();
        dec_valid = 1'b0;
        dec_rs1 = 5'($urandom); dec_rs2 = 5'($urandom); dec_rd = 5'($urandom);
        dec_use_rs1 = 1'($urandom); dec_use_rs2 = 1'($urandom); dec_wr_rd = 1'($urandom);
        dec_payload = $urandom;

        lat = 0;
        seen = 1'b0;
        while (lat < expLat + 20) begin
            lat++;
            wb_we   = (lat == wbAt);
            wb_addr = wbAddr;
            wb_data = wbData;
            sampleCycle();
            if (ex_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            advance();
        end
        wb_we = 1'b0;
        checkOutput("latency", 32'(lat), 32'(expLat));
        if (!seen) begin
            doReset();
            return;
        end

        for (int h = 0; h <= hold; h++) begin
            checkOutput("ex_valid", 32'(ex_valid), 32'd1);
            checkOutput("ex_op1", ex_op1, e1);
            checkOutput("ex_op2", ex_op2, e2);
            checkOutput("ex_payload", ex_payload, payload);
            checkOutput("ex_rd", 32'(ex_rd), 32'(rd));
            checkOutput("ex_wr_rd", 32'(ex_wr_rd), 32'(wr));
            checkOutput("dec_ready_busy", 32'(dec_ready), 32'd0);
            if (h == hold) ex_ready = 1'b1;
            advance();
            if (h < hold) sampleCycle();
        end
        ex_ready = 1'b0;

        checkOutput("re_p0_count", 32'(re0Cnt), 32'(reads1));
        checkOutput("re_p1_count", 32'(re1Cnt), 32'(reads2));
        checkOutput("we_pi_count", 32'(weCnt), (wr && rd != 5'd0) ? 32'd1 : 32'd0);
        if (wr && rd != 5'd0) checkOutput("we_pi_addr", 32'(piAddr), 32'(rd));
        checkOutput("stall_cnt", 32'(stall_cnt), 32'(stallModel));
        sampleCycle();
        checkOutput("back_idle_ready", 32'(dec_ready), 32'd1);
        checkOutput("back_idle_valid", 32'(ex_valid), 32'd0);
        advance();
    endtask

    initial begin
        logic [4:0] r1, r2, wa;
        int         wat;
        reset = 1'b1;
        dec_valid = 1'b0; dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_rd = 5'd0;
        dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0; dec_wr_rd = 1'b0; dec_payload = 32'd0;
        rf_dout_p0 = 32'd0; rf_v_p0 = 1'b0; rf_dout_p1 = 32'd0; rf_v_p1 = 1'b0;
        wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; ex_ready = 1'b0;
        stallModel = 0;
        re0Cnt = 0; re1Cnt = 0; weCnt = 0; piAddr = 5'd0;
        for (int i = 0; i < 32; i++) begin
            regs[i] = (i == 0) ? 32'd0 : $urandom;
            pend[i] = 0;
        end

        sampleCycle();
        advance();
        sampleCycle();
        checkOutput("rst_dec_ready", 32'(dec_ready), 32'd0);
        checkOutput("rst_ex_valid", 32'(ex_valid), 32'd0);
        checkOutput("rst_rf_re", 32'({rf_re_p0, rf_re_p1}), 32'd0);
        checkOutput("rst_we_pi", 32'(rf_we_pi), 32'd0);
        checkOutput("rst_stall", 32'(stall_cnt), 32'd0);
        checkOutput("rst_ex_op1", ex_op1, 32'd0);
        checkOutput("rst_ex_op2", ex_op2, 32'd0);
        checkOutput("rst_ex_payload", ex_payload, 32'd0);
        checkOutput("rst_ex_rd", 32'({ex_wr_rd, ex_rd}), 32'd0);
        advance();
        reset = 1'b0;
        sampleCycle();
        checkOutput("post_rst_dec_ready", 32'(dec_ready), 32'd1);
        advance();

        // Both sources valid, destination invalidated once.
        regs[5] = 32'h11; regs[6] = 32'h22;
        applyStimulus(5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 1'b1, 32'hCAFE0001, 0, 0, 0, 0, 5'd0, 32'd0);
        // rs1 invalid twice, writeback during the second CHECK.
        applyStimulus(5'd9, 5'd2, 5'd4, 1'b1, 1'b0, 1'b1, 32'hCAFE0002, 2, 0, 0, 4, 5'd9, 32'hABCD);
        // Writeback of rs2 in READ: stale register-file data must be ignored.
        regs[3] = 32'hDEAD0003;
        applyStimulus(5'd10, 5'd3, 5'd11, 1'b1, 1'b1, 1'b0, 32'hCAFE0003, 0, 0, 0, 1, 5'd3, 32'h55);
        // x0 and unused source, rd=x0: no reads, no invalidation.
        applyStimulus(5'd0, 5'd12, 5'd0, 1'b1, 1'b0, 1'b1, 32'hCAFE0004, 0, 0, 0, 0, 5'd0, 32'd0);
        // Execute back-pressure for 4 cycles; rd equal to a source.
        applyStimulus(5'd14, 5'd14, 5'd14, 1'b1, 1'b1, 1'b1, 32'hCAFE0005, 1, 1, 4, 0, 5'd0, 32'd0);

        // Reset while in CHECK: no invalidation, back to IDLE with cleared outputs.
        re0Cnt = 0; re1Cnt = 0; weCnt = 0;
        dec_rs1 = 5'd5; dec_rs2 = 5'd6; dec_rd = 5'd7;
        dec_use_rs1 = 1'b1; dec_use_rs2 = 1'b1; dec_wr_rd = 1'b1; dec_payload = 32'h1234;
        dec_valid = 1'b1;
        sampleCycle();
        advance();
        dec_valid = 1'b0;
        sampleCycle();
        advance();
        reset = 1'b1;
        sampleCycle();
        checkOutput("rstchk_we_pi", 32'(rf_we_pi), 32'd0);
        checkOutput("rstchk_ex_valid", 32'(ex_valid), 32'd0);
        advance();
        reset = 1'b0;
        stallModel = 0;
        sampleCycle();
        checkOutput("rstchk_idle_ready", 32'(dec_ready), 32'd1);
        checkOutput("rstchk_ex_valid_after", 32'(ex_valid), 32'd0);
        checkOutput("rstchk_ex_op1", ex_op1, 32'd0);
        checkOutput("rstchk_ex_payload", ex_payload, 32'd0);
        checkOutput("rstchk_we_count", 32'(weCnt), 32'd0);
        checkOutput("rstchk_stall", 32'(stall_cnt), 32'd0);
        advance();

        // Randomized instructions.
        for (int n = 0; n < 30; n++) begin
            r1 = 5'($urandom_range(31));
            r2 = ($urandom_range(3) == 0) ? r1 : 5'($urandom_range(31));
            if (r1 != 5'd0) regs[r1] = $urandom;
            if (r2 != 5'd0) regs[r2] = $urandom;
            wat = ($urandom_range(1) == 1) ? int'($urandom_range(6, 1)) : 0;
            wa  = ($urandom_range(1) == 1) ? r1 : r2;
            if (wa == 5'd0) wat = 0;
            applyStimulus(r1, r2, 5'($urandom_range(31)), 1'($urandom), 1'($urandom), 1'($urandom),
                          $urandom, int'($urandom_range(2)), int'($urandom_range(2)),
                          int'($urandom_range(3)), wat, wa, $urandom);
        end

        // Saturation of the stall counter, then a further retry holds it.
        doReset();
        applyStimulus(5'd13, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 32'hCAFE0006, 45, 0, 0, 0, 5'd0, 32'd0);
        applyStimulus(5'd15, 5'd16, 5'd1, 1'b1, 1'b1, 1'b1, 32'hCAFE0007, 2, 1, 0, 0, 5'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
